// File: rtl/tdm_demux_4ch.sv
// rtl/tdm_demux_4ch.sv - 4-slot TDM receive demux with framing-error detection
// Rebuilds {ch3,ch2,ch1,ch0} frames from a slot stream and counts framing errors.
module tdm_demux_4ch #(
  parameter int WIDTH       = 1,
  parameter int STRICT_SYNC = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [4*WIDTH-1:0]   dout,
  output logic                 dout_valid,
  output logic [1:0]           slot,
  output logic                 locked,
  output logic                 sync_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t               r_state;
  logic [1:0]           r_slot;
  logic [WIDTH-1:0]     r_sh0, r_sh1, r_sh2;
  logic [4*WIDTH-1:0]   r_dout;
  logic                 r_dout_valid;
  logic                 r_sync_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic w_run_beat;
  logic w_early;
  logic w_lost;
  logic w_err;

  assign w_run_beat = din_valid && (r_state == RUN);
  assign w_early    = w_run_beat && (r_slot != 2'd0) && frame_sync;
  assign w_lost     = w_run_beat && (r_slot == 2'd0) && !frame_sync && (STRICT_SYNC != 0);
  assign w_err      = w_early || w_lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_slot       <= 2'd0;
      r_sh0        <= '0;
      r_sh1        <= '0;
      r_sh2        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      r_sync_err   <= w_err;
      if (w_err && (r_err_count != {ERR_CNT_W{1'b1}}))
        r_err_count <= r_err_count + 1'b1;

      if (din_valid) begin
        case (r_state)
          HUNT: begin
            if (frame_sync) begin
              r_sh0   <= din;
              r_slot  <= 2'd1;
              r_state <= RUN;
            end
          end
          RUN: begin
            if (w_early) begin
              r_sh0  <= din;
              r_slot <= 2'd1;
            end else if (w_lost) begin
              r_slot  <= 2'd0;
              r_state <= HUNT;
            end else begin
              case (r_slot)
                2'd0: r_sh0 <= din;
                2'd1: r_sh1 <= din;
                2'd2: r_sh2 <= din;
                default: begin
                  // Slot 3 is never shadowed: it goes straight into the frame.
                  r_dout       <= {din, r_sh2, r_sh1, r_sh0};
                  r_dout_valid <= 1'b1;
                end
              endcase
              r_slot <= r_slot + 2'd1;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign slot       = r_slot;
  assign locked     = (r_state == RUN);
  assign sync_err   = r_sync_err;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb/tb_tdm_demux_4ch.sv - directed bench for tdm_demux_4ch
// Strict and free-running instances share one stimulus stream.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;

  logic [3:0] s_dout, f_dout;
  logic       s_dv, f_dv;
  logic [1:0] s_slot, f_slot;
  logic       s_locked, f_locked;
  logic       s_err, f_err;
  logic [7:0] s_cnt, f_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdm_demux_4ch #(.WIDTH(1), .STRICT_SYNC(1), .ERR_CNT_W(8)) u_strict (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .dout(s_dout), .dout_valid(s_dv), .slot(s_slot), .locked(s_locked),
    .sync_err(s_err), .err_count(s_cnt)
  );

  tdm_demux_4ch #(.WIDTH(1), .STRICT_SYNC(0), .ERR_CNT_W(8)) u_free (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .dout(f_dout), .dout_valid(f_dv), .slot(f_slot), .locked(f_locked),
    .sync_err(f_err), .err_count(f_cnt)
  );

  task automatic beat(input logic v, input logic s, input logic d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({s_dout, s_dv, s_slot, s_locked, s_err, s_cnt} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {s_dout, s_dv, s_slot, s_locked, s_err, s_cnt});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_hunt_drop;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b0, i[0]);
      checks++; if ({s_dv, s_err, s_locked, f_dv, f_err, f_locked} !== 6'd0) begin
        errors++; $display("FAIL hunt_drop_flags got %b exp 000000", {s_dv, s_err, s_locked, f_dv, f_err, f_locked});
      end
    end
    checks++; if (s_cnt !== 8'd0) begin
      errors++; $display("FAIL hunt_drop_cnt got %0d exp 0", s_cnt);
    end
  endtask

  task automatic test_basic_frame;
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    checks++; if (s_dv !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid got %b exp 0", s_dv);
    end
    beat(1'b1, 1'b0, 1'b1);
    checks++; if (s_dout !== 4'b1101 || s_dv !== 1'b1 || s_locked !== 1'b1) begin
      errors++; $display("FAIL basic_frame got dout=%b dv=%b lk=%b exp 1101 1 1", s_dout, s_dv, s_locked);
    end
    checks++; if (f_dout !== 4'b1101 || f_dv !== 1'b1) begin
      errors++; $display("FAIL basic_frame_free got dout=%b dv=%b exp 1101 1", f_dout, f_dv);
    end
    beat(1'b0, 1'b0, 1'b0);
    checks++; if (s_dv !== 1'b0 || s_dout !== 4'b1101 || s_slot !== 2'd0) begin
      errors++; $display("FAIL basic_hold got dv=%b dout=%b slot=%0d exp 0 1101 0", s_dv, s_dout, s_slot);
    end
  endtask

  task automatic test_early_sync;
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    checks++; if (s_err !== 1'b1 || s_cnt !== 8'd1 || s_dout !== 4'b1101 || s_dv !== 1'b0 || s_slot !== 2'd1) begin
      errors++; $display("FAIL early_sync got err=%b cnt=%0d dout=%b dv=%b slot=%0d exp 1 1 1101 0 1", s_err, s_cnt, s_dout, s_dv, s_slot);
    end
    beat(1'b1, 1'b0, 1'b0);
    checks++; if (s_err !== 1'b0) begin
      errors++; $display("FAIL early_sync_pulse got %b exp 0", s_err);
    end
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    checks++; if (s_dout !== 4'b0101 || s_dv !== 1'b1 || f_dout !== 4'b0101 || f_cnt !== 8'd1) begin
      errors++; $display("FAIL early_resync_frame got s=%b dv=%b f=%b fcnt=%0d exp 0101 1 0101 1", s_dout, s_dv, f_dout, f_cnt);
    end
  endtask

  task automatic test_strict_vs_free;
    beat(1'b1, 1'b0, 1'b1);
    checks++; if (s_err !== 1'b1 || s_locked !== 1'b0 || s_slot !== 2'd0 || s_cnt !== 8'd2) begin
      errors++; $display("FAIL strict_lost got err=%b lk=%b slot=%0d cnt=%0d exp 1 0 0 2", s_err, s_locked, s_slot, s_cnt);
    end
    checks++; if (f_err !== 1'b0 || f_locked !== 1'b1 || f_slot !== 2'd1 || f_cnt !== 8'd1) begin
      errors++; $display("FAIL free_accept got err=%b lk=%b slot=%0d cnt=%0d exp 0 1 1 1", f_err, f_locked, f_slot, f_cnt);
    end
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    checks++; if (f_dout !== 4'b1101 || f_dv !== 1'b1) begin
      errors++; $display("FAIL free_frame got dout=%b dv=%b exp 1101 1", f_dout, f_dv);
    end
    checks++; if (s_dout !== 4'b0101 || s_dv !== 1'b0 || s_cnt !== 8'd2 || s_locked !== 1'b0) begin
      errors++; $display("FAIL strict_hunt_hold got dout=%b dv=%b cnt=%0d lk=%b exp 0101 0 2 0", s_dout, s_dv, s_cnt, s_locked);
    end
  endtask

  task automatic test_gapped;
    logic [3:0] frames [3];
    logic [3:0] fr;
    int pulses;
    frames[0] = 4'b0111;
    frames[1] = 4'b1100;
    frames[2] = 4'b1001;
    pulses = 0;
    for (int f = 0; f < 3; f++) begin
      fr = frames[f];
      for (int b = 0; b < 4; b++) begin
        beat(1'b1, (b == 0), fr[b]);
        if (s_dv) pulses++;
        if (b == 3) begin
          checks++; if (s_dout !== fr || f_dout !== fr) begin
            errors++; $display("FAIL gapped_frame%0d got s=%b f=%b exp %b", f, s_dout, f_dout, fr);
          end
        end
        for (int g = 0; g < 2; g++) begin
          beat(1'b0, 1'b0, 1'b0);
          if (s_dv) pulses++;
        end
      end
    end
    checks++; if (pulses !== 3) begin
      errors++; $display("FAIL gapped_pulses got %0d exp 3", pulses);
    end
  endtask

  task automatic test_midframe_reset;
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({s_dout, s_dv, s_slot, s_locked, s_err, s_cnt} !== 17'd0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {s_dout, s_dv, s_slot, s_locked, s_err, s_cnt});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    checks++; if (s_dout !== 4'b0110 || s_dv !== 1'b1 || s_cnt !== 8'd0) begin
      errors++; $display("FAIL post_reset_frame got dout=%b dv=%b cnt=%0d exp 0110 1 0", s_dout, s_dv, s_cnt);
    end
  endtask

  task automatic test_saturate;
    // First sync beat lands on slot 0 (no error); each later one is an early sync.
    for (int i = 0; i < 301; i++) begin
      beat(1'b1, 1'b1, 1'b0);
      if (i == 255) begin
        checks++; if (s_cnt !== 8'd255) begin
          errors++; $display("FAIL sat_reach got %0d exp 255", s_cnt);
        end
      end
    end
    checks++; if (s_cnt !== 8'd255 || f_cnt !== 8'd255 || s_err !== 1'b1) begin
      errors++; $display("FAIL sat_hold got s=%0d f=%0d err=%b exp 255 255 1", s_cnt, f_cnt, s_err);
    end
    checks++; if (s_dout !== 4'b0110) begin
      errors++; $display("FAIL sat_dout_held got %b exp 0110", s_dout);
    end
  endtask

  initial begin
    test_reset();
    test_hunt_drop();
    test_basic_frame();
    test_early_sync();
    test_strict_vs_free();
    test_gapped();
    test_midframe_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
